// File: rtl/hls_seq_pkg.sv
// Shared types and constants for the HLS invocation sequencer.
package hls_seq_pkg;

  // Pointer width for a FIFO of the given depth; never narrower than one bit.
  function automatic int seq_ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int SEQ_CNT_W   = 16;
  localparam int SEQ_TS_W    = 32;
  localparam int SEQ_MAX_OUT = 4;
  localparam int SEQ_PTR_W   = seq_ptr_w(SEQ_MAX_OUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } seq_state_e;

  // Latency statistics at the default widths.
  typedef struct packed {
    logic [SEQ_TS_W-1:0]           min_lat;
    logic [SEQ_TS_W-1:0]           max_lat;
    logic [SEQ_TS_W+SEQ_CNT_W-1:0] sum_lat;
  } lat_stats_t;

endpackage

// File: rtl/hls_ts_fifo.sv
// Synchronous timestamp FIFO. Push and pop may happen in the same cycle,
// including when full; count reports current occupancy.
module hls_ts_fifo
  import hls_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = seq_ptr_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  // A full FIFO still accepts a push when the same cycle pops.
  assign w_do_push = push && (!w_full || pop);
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hls_invocation_sequencer.sv
// Drives an HLS kernel's ap_ctrl block handshake for a programmed number of
// invocations, keeping up to MAX_OUT in flight and collecting latency stats.
//
// Handshake: ap_start is a valid that depends only on registered state; a start
// is consumed in any cycle where ap_start && ap_ready at the rising edge. ap_done
// is a single-cycle completion pulse with no back-pressure; completions are
// matched to starts in order through the timestamp FIFO. ap_continue mirrors busy.
module hls_invocation_sequencer
  import hls_seq_pkg::*;
#(
  parameter int CNT_W   = SEQ_CNT_W,
  parameter int TS_W    = SEQ_TS_W,
  parameter int MAX_OUT = SEQ_MAX_OUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [CNT_W-1:0]      cfg_count,
  output logic                  busy,
  output logic                  all_done,
  output logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  output logic                  ap_continue,
  output logic [CNT_W-1:0]      stat_issued,
  output logic [CNT_W-1:0]      stat_completed,
  output logic [TS_W-1:0]       stat_min_lat,
  output logic [TS_W-1:0]       stat_max_lat,
  output logic [TS_W+CNT_W-1:0] stat_sum_lat,
  output logic                  err_spurious,
  output logic [1:0]            dbg_state
);

  localparam int             PTR_W   = seq_ptr_w(MAX_OUT);
  localparam logic [PTR_W:0] MAX_CNT = MAX_OUT[PTR_W:0];

  seq_state_e              r_state;
  seq_state_e              w_state_nxt;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        r_issued;
  logic [CNT_W-1:0]        r_completed;
  logic [TS_W-1:0]         r_ts;
  logic [TS_W-1:0]         r_min;
  logic [TS_W-1:0]         r_max;
  logic [TS_W+CNT_W-1:0]   r_sum;
  logic                    r_err;
  logic                    r_all_done;

  logic [TS_W-1:0]         w_pop_ts;
  logic [TS_W-1:0]         w_lat;
  logic [PTR_W:0]          w_outstanding;
  logic                    w_empty;
  logic                    w_cfg_accept;
  logic                    w_accept;
  logic                    w_active;
  logic                    w_done_valid;
  logic                    w_done_spur;

  // In-flight start timestamps, oldest first.
  hls_ts_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TS_W)
  ) u_ts_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_accept),
    .push_data (r_ts),
    .pop       (w_done_valid),
    .pop_data  (w_pop_ts),
    .count     (w_outstanding),
    .empty     (w_empty)
  );

  assign w_cfg_accept = cfg_start && (r_state == IDLE);
  assign w_active     = (r_state == ISSUE) || (r_state == DRAIN);
  assign ap_start     = (r_state == ISSUE) && (r_issued < r_count) &&
                        (w_outstanding < MAX_CNT);
  assign w_accept     = ap_start && ap_ready;
  assign w_done_valid = ap_done && w_active && !w_empty;
  assign w_done_spur  = ap_done && w_active && w_empty;
  // Modular subtraction keeps latency correct across a timestamp wrap.
  assign w_lat        = r_ts - w_pop_ts;

  assign busy           = (r_state != IDLE);
  assign ap_continue    = busy;
  assign all_done       = r_all_done;
  assign stat_issued    = r_issued;
  assign stat_completed = r_completed;
  assign stat_min_lat   = r_min;
  assign stat_max_lat   = r_max;
  assign stat_sum_lat   = r_sum;
  assign err_spurious   = r_err;
  assign dbg_state      = r_state;

  // Free-running timestamp, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  // Run sequencing: issue all starts, wait for all completions, then finish.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (cfg_start) w_state_nxt = (cfg_count == '0) ? FIN : ISSUE;
      end
      ISSUE: begin
        if (w_accept && (r_issued + 1'b1 == r_count)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // FIN is entered together with the final stats update.
        if (w_done_valid && (r_completed + 1'b1 == r_count)) w_state_nxt = FIN;
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Completion pulse lands the cycle after FIN, together with busy falling.
  always_ff @(posedge clock) begin
    if (reset) r_all_done <= 1'b0;
    else       r_all_done <= (r_state == FIN);
  end

  // Run counters, latency statistics and the sticky spurious-done flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      r_min       <= '1;
      r_max       <= '0;
      r_sum       <= '0;
      r_err       <= 1'b0;
    end else if (w_cfg_accept) begin
      r_count     <= cfg_count;
      r_issued    <= '0;
      r_completed <= '0;
      r_min       <= '1;
      r_max       <= '0;
      r_sum       <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) r_issued <= r_issued + 1'b1;
      if (w_done_valid) begin
        r_completed <= r_completed + 1'b1;
        r_sum       <= r_sum + {{CNT_W{1'b0}}, w_lat};
        if (w_lat < r_min) r_min <= w_lat;
        if (w_lat > r_max) r_max <= w_lat;
      end
      if (w_done_spur) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hls_invocation_sequencer.sv
// Self-checking bench for hls_invocation_sequencer: a fixed-latency kernel stub,
// an expected-latency queue filled at each accepted start, and per-scenario tasks.
module tb_hls_invocation_sequencer;
  import hls_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- main DUT (default widths) ----------------
  logic        cfg_start;
  logic [15:0] cfg_count;
  logic        busy, all_done, ap_start, ap_ready, ap_done, ap_continue;
  logic [15:0] stat_issued, stat_completed;
  logic [31:0] stat_min_lat, stat_max_lat;
  logic [47:0] stat_sum_lat;
  logic        err_spurious;
  logic [1:0]  dbg_state;

  hls_invocation_sequencer u_dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_count      (cfg_count),
    .busy           (busy),
    .all_done       (all_done),
    .ap_start       (ap_start),
    .ap_ready       (ap_ready),
    .ap_done        (ap_done),
    .ap_continue    (ap_continue),
    .stat_issued    (stat_issued),
    .stat_completed (stat_completed),
    .stat_min_lat   (stat_min_lat),
    .stat_max_lat   (stat_max_lat),
    .stat_sum_lat   (stat_sum_lat),
    .err_spurious   (err_spurious),
    .dbg_state      (dbg_state)
  );

  // ---------------- narrow-timestamp DUT (TS_W = 8) ----------------
  logic        reset8, cfg_start8, ap_ready8, ap_done8;
  logic [15:0] cfg_count8;
  logic        busy8, all_done8, ap_start8, ap_continue8, err8;
  logic [15:0] issued8, completed8;
  logic [7:0]  min8, max8;
  logic [23:0] sum8;
  logic [1:0]  state8;

  hls_invocation_sequencer #(.CNT_W(16), .TS_W(8), .MAX_OUT(4)) u_dut8 (
    .clock          (clock),
    .reset          (reset8),
    .cfg_start      (cfg_start8),
    .cfg_count      (cfg_count8),
    .busy           (busy8),
    .all_done       (all_done8),
    .ap_start       (ap_start8),
    .ap_ready       (ap_ready8),
    .ap_done        (ap_done8),
    .ap_continue    (ap_continue8),
    .stat_issued    (issued8),
    .stat_completed (completed8),
    .stat_min_lat   (min8),
    .stat_max_lat   (max8),
    .stat_sum_lat   (sum8),
    .err_spurious   (err8),
    .dbg_state      (state8)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  lat_stats_t  m_stats;
  int          m_count, m_issued, m_completed;
  int          m_out, m_max_out, m_stall, m_start_cycles, m_coincide3, m_start_full;
  int          m_stats_cyc, m_all_done_cyc;

  // ---------------- driver tasks ----------------
  // Pulse cfg_start for one edge; returns at the negedge after it was sampled.
  task automatic start_run(input logic [15:0] cnt);
    cfg_count = cnt;
    cfg_start = 1'b1;
    @(posedge clock); @(negedge clock);
    cfg_start = 1'b0;
    m_count = int'(cnt);
    m_issued = 0; m_completed = 0;
    m_stats.min_lat = '1; m_stats.max_lat = '0; m_stats.sum_lat = '0;
    exp_q.delete();
    m_out = 0; m_max_out = 0; m_stall = 0; m_start_cycles = 0;
    m_coincide3 = 0; m_start_full = 0;
    m_stats_cyc = -1; m_all_done_cyc = -1;
  endtask

  // Kernel stub (always ready, fixed latency) plus scoreboard; runs until all_done.
  task automatic drive_run(input int lat, input int budget);
    int          due_q[$];
    logic [31:0] e;
    bit          done_now, acc_now, finished;
    finished = 1'b0;
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      done_now = (due_q.size() > 0) && (due_q[0] == cyc);
      if (done_now) void'(due_q.pop_front());
      ap_ready = 1'b1;
      ap_done  = done_now;
      acc_now  = (ap_start === 1'b1);
      if (acc_now) m_start_cycles++;
      else if (m_issued < m_count) m_stall++;
      if (acc_now && m_out >= 4) m_start_full++;
      if (acc_now && done_now && m_out == 3) m_coincide3++;
      if (acc_now) begin
        due_q.push_back(cyc + lat);
        exp_q.push_back(32'(lat));
        m_issued++;
      end
      m_out = m_out + int'(acc_now) - int'(done_now);
      if (m_out > m_max_out) m_max_out = m_out;
      @(posedge clock); @(negedge clock);
      ap_done = 1'b0;
      if (done_now) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got=done_with_empty_queue required=queued_start");
        end else begin
          e = exp_q.pop_front();
          m_completed++;
          m_stats.sum_lat = m_stats.sum_lat + {16'b0, e};
          if (e < m_stats.min_lat) m_stats.min_lat = e;
          if (e > m_stats.max_lat) m_stats.max_lat = e;
          if (stat_completed !== 16'(m_completed) || stat_sum_lat !== m_stats.sum_lat ||
              stat_min_lat !== m_stats.min_lat || stat_max_lat !== m_stats.max_lat) begin
            errors++;
            $display("FAIL sb_stats got=cmp%0d/sum%0d/min%0d/max%0d required=cmp%0d/sum%0d/min%0d/max%0d",
                     stat_completed, stat_sum_lat, stat_min_lat, stat_max_lat,
                     m_completed, m_stats.sum_lat, m_stats.min_lat, m_stats.max_lat);
          end
        end
        m_stats_cyc = cyc + 1;
      end
      if (acc_now) begin
        checks++;
        if (stat_issued !== 16'(m_issued)) begin
          errors++;
          $display("FAIL sb_issued got=%0d required=%0d", stat_issued, m_issued);
        end
      end
      if (all_done === 1'b1) begin
        finished = 1'b1;
        m_all_done_cyc = cyc + 1;
      end
    end
    ap_ready = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL run_timeout got=no_all_done required=all_done within %0d cycles", budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; reset8 = 1'b1;
    cfg_start = 1'b0; cfg_count = '0; ap_ready = 1'b0; ap_done = 1'b0;
    cfg_start8 = 1'b0; cfg_count8 = '0; ap_ready8 = 1'b0; ap_done8 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({busy, all_done, ap_start, ap_continue, err_spurious} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=00000",
               {busy, all_done, ap_start, ap_continue, err_spurious});
    end
    checks++;
    if (stat_issued !== 16'd0 || stat_completed !== 16'd0 || stat_sum_lat !== 48'd0) begin
      errors++;
      $display("FAIL reset_counts got=%0d/%0d/%0d required=0/0/0",
               stat_issued, stat_completed, stat_sum_lat);
    end
    checks++;
    if (stat_min_lat !== 32'hFFFF_FFFF || stat_max_lat !== 32'd0) begin
      errors++;
      $display("FAIL reset_minmax got=%h/%h required=ffffffff/00000000", stat_min_lat, stat_max_lat);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d required=0", dbg_state);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    start_run(16'd1);
    checks++;
    if ({busy, ap_continue, ap_start} !== 3'b111) begin
      errors++;
      $display("FAIL single_start got=%b required=111", {busy, ap_continue, ap_start});
    end
    drive_run(8, 40);
    checks++;
    if (m_start_cycles != 1) begin
      errors++;
      $display("FAIL single_ap_start_cycles got=%0d required=1", m_start_cycles);
    end
    checks++;
    if (stat_min_lat !== 32'd8 || stat_max_lat !== 32'd8 || stat_sum_lat !== 48'd8) begin
      errors++;
      $display("FAIL single_lat got=%0d/%0d/%0d required=8/8/8", stat_min_lat, stat_max_lat, stat_sum_lat);
    end
    checks++;
    if (m_all_done_cyc != m_stats_cyc + 1) begin
      errors++;
      $display("FAIL single_done_timing got=%0d required=%0d", m_all_done_cyc, m_stats_cyc + 1);
    end
    checks++;
    if (busy !== 1'b0 || ap_continue !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_drop got=%b%b required=00", busy, ap_continue);
    end
    @(negedge clock);
    checks++;
    if (all_done !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL single_pulse_width got=%b/%0d required=0/0", all_done, dbg_state);
    end
  endtask

  task automatic test_pipelined();
    start_run(16'd10);
    drive_run(8, 200);
    checks++;
    if (stat_issued !== 16'd10 || stat_completed !== 16'd10 || stat_sum_lat !== 48'd80) begin
      errors++;
      $display("FAIL pipe_totals got=%0d/%0d/%0d required=10/10/80", stat_issued, stat_completed, stat_sum_lat);
    end
    checks++;
    if (stat_min_lat !== 32'd8 || stat_max_lat !== 32'd8 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL pipe_minmax_err got=%0d/%0d/%b required=8/8/0", stat_min_lat, stat_max_lat, err_spurious);
    end
    checks++;
    if (m_max_out != 4 || m_stall == 0 || m_start_full != 0) begin
      errors++;
      $display("FAIL pipe_throttle got=maxout%0d/stall%0d/startfull%0d required=4/nonzero/0",
               m_max_out, m_stall, m_start_full);
    end
    @(negedge clock);
  endtask

  task automatic test_zero_count();
    // ap_done while idle is ignored and previous stats hold.
    ap_done = 1'b1;
    @(posedge clock); @(negedge clock);
    ap_done = 1'b0;
    checks++;
    if (err_spurious !== 1'b0 || stat_completed !== 16'd10) begin
      errors++;
      $display("FAIL idle_done got=%b/%0d required=0/10", err_spurious, stat_completed);
    end
    ap_ready = 1'b1;
    start_run(16'd0);
    checks++;
    if (all_done !== 1'b0 || ap_start !== 1'b0 || stat_issued !== 16'd0 || stat_completed !== 16'd0 ||
        stat_sum_lat !== 48'd0 || stat_min_lat !== 32'hFFFF_FFFF || stat_max_lat !== 32'd0) begin
      errors++;
      $display("FAIL zero_cleared got=%b/%b/%0d/%0d/%0d/%h/%0d required=0/0/0/0/0/ffffffff/0",
               all_done, ap_start, stat_issued, stat_completed, stat_sum_lat, stat_min_lat, stat_max_lat);
    end
    @(negedge clock);
    checks++;
    if (all_done !== 1'b1 || busy !== 1'b0 || ap_start !== 1'b0) begin
      errors++;
      $display("FAIL zero_all_done got=%b/%b/%b required=1/0/0", all_done, busy, ap_start);
    end
    @(negedge clock);
    checks++;
    if (all_done !== 1'b0 || ap_start !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL zero_after got=%b/%b/%0d required=0/0/0", all_done, ap_start, dbg_state);
    end
    ap_ready = 1'b0;
  endtask

  task automatic test_coincide();
    start_run(16'd10);
    drive_run(3, 100);
    checks++;
    if (m_coincide3 == 0 || m_stall != 0 || m_max_out != 3) begin
      errors++;
      $display("FAIL coincide_occupancy got=coin%0d/stall%0d/maxout%0d required=nonzero/0/3",
               m_coincide3, m_stall, m_max_out);
    end
    checks++;
    if (stat_completed !== 16'd10 || stat_sum_lat !== 48'd30 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL coincide_totals got=%0d/%0d/%b required=10/30/0", stat_completed, stat_sum_lat, err_spurious);
    end
    @(negedge clock);
  endtask

  task automatic test_spurious();
    ap_ready = 1'b0;
    start_run(16'd2);
    ap_done = 1'b1;
    @(posedge clock); @(negedge clock);
    ap_done = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || stat_completed !== 16'd0) begin
      errors++;
      $display("FAIL spurious_flag got=%b/%0d required=1/0", err_spurious, stat_completed);
    end
    drive_run(4, 60);
    checks++;
    if (err_spurious !== 1'b1 || stat_completed !== 16'd2) begin
      errors++;
      $display("FAIL spurious_sticky got=%b/%0d required=1/2", err_spurious, stat_completed);
    end
    @(negedge clock);
    start_run(16'd1);
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL spurious_clear got=%b required=0", err_spurious);
    end
    drive_run(5, 60);
    checks++;
    if (stat_sum_lat !== 48'd5 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL spurious_rerun got=%0d/%b required=5/0", stat_sum_lat, err_spurious);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_run();
    ap_ready = 1'b1;
    start_run(16'd10);
    repeat (3) begin
      @(posedge clock); @(negedge clock);
    end
    checks++;
    if (stat_issued !== 16'd3) begin
      errors++;
      $display("FAIL midrst_issued got=%0d required=3", stat_issued);
    end
    ap_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({busy, all_done, ap_start, ap_continue, err_spurious} !== 5'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midrst_ctrl got=%b/%0d required=00000/0",
               {busy, all_done, ap_start, ap_continue, err_spurious}, dbg_state);
    end
    checks++;
    if (stat_issued !== 16'd0 || stat_completed !== 16'd0 || stat_sum_lat !== 48'd0 ||
        stat_min_lat !== 32'hFFFF_FFFF || stat_max_lat !== 32'd0) begin
      errors++;
      $display("FAIL midrst_stats got=%0d/%0d/%0d/%h/%0d required=0/0/0/ffffffff/0",
               stat_issued, stat_completed, stat_sum_lat, stat_min_lat, stat_max_lat);
    end
    // A late completion from the interrupted run must be ignored.
    ap_done = 1'b1;
    @(posedge clock); @(negedge clock);
    ap_done = 1'b0;
    checks++;
    if (err_spurious !== 1'b0 || stat_completed !== 16'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midrst_late_done got=%b/%0d/%0d required=0/0/0", err_spurious, stat_completed, dbg_state);
    end
  endtask

  task automatic test_ts_wrap();
    bit seen;
    // Timestamp is 0 in the first cycle after reset, so the start lands at 246.
    reset8 = 1'b1;
    @(posedge clock); @(negedge clock);
    reset8 = 1'b0;
    repeat (245) @(negedge clock);
    cfg_count8 = 16'd1;
    cfg_start8 = 1'b1;
    ap_ready8  = 1'b1;
    @(posedge clock); @(negedge clock);
    cfg_start8 = 1'b0;
    checks++;
    if (ap_start8 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_start got=%b required=1", ap_start8);
    end
    @(posedge clock); @(negedge clock);
    ap_ready8 = 1'b0;
    repeat (9) @(negedge clock);
    ap_done8 = 1'b1;
    @(posedge clock); @(negedge clock);
    ap_done8 = 1'b0;
    checks++;
    if (min8 !== 8'd10 || max8 !== 8'd10 || sum8 !== 24'd10 || completed8 !== 16'd1 || err8 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_latency got=%0d/%0d/%0d/%0d/%b required=10/10/10/1/0",
               min8, max8, sum8, completed8, err8);
    end
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (all_done8 === 1'b1) seen = 1'b1;
      else @(negedge clock);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wrap_all_done got=no_pulse required=pulse within 5 cycles");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_pipelined();
    test_zero_count();
    test_coincide();
    test_spurious();
    test_reset_mid_run();
    test_ts_wrap();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
